// File: rtl/ahb_lite_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_lite_master_pkg : shared AHB-Lite encodings, FSM states and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package ahb_lite_master_pkg;

   localparam int BUS_WIDTH = 32;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001
   } hburst_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // Sizes wider than the 32-bit bus are forced down to a word.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      return (size > HSIZE_WORD) ? HSIZE_WORD : size;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_lite_master_if : user command/response and AHB-Lite bus signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface ahb_lite_master_if #(
   parameter int MAX_LEN = 16
);
   import ahb_lite_master_pkg::*;

   localparam int LEN_W = $clog2(MAX_LEN) + 1;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [BUS_WIDTH-1:0] cmd_addr;
   logic [2:0]           cmd_size;
   logic [LEN_W-1:0]     cmd_len;
   logic [BUS_WIDTH-1:0] wr_data;
   logic                 wr_pop;
   logic                 rd_valid;
   logic [BUS_WIDTH-1:0] rd_data;
   logic                 done;
   logic                 done_err;

   logic [BUS_WIDTH-1:0] HADDR;
   logic                 HWRITE;
   logic [2:0]           HSIZE;
   logic [2:0]           HBURST;
   logic [3:0]           HPROT;
   logic [1:0]           HTRANS;
   logic                 HMASTLOCK;
   logic [BUS_WIDTH-1:0] HWDATA;
   logic                 HREADY;
   logic                 HRESP;
   logic [BUS_WIDTH-1:0] HRDATA;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data,
      output cmd_ready, wr_pop, rd_valid, rd_data, done, done_err,
      output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
      input  HREADY, HRESP, HRDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data,
      input  cmd_ready, wr_pop, rd_valid, rd_data, done, done_err,
      input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
      output HREADY, HRESP, HRDATA
   );

endinterface
`default_nettype wire

// File: rtl/ahb_lite_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_lite_addr_gen : burst beat counter and address incrementer
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb_lite_addr_gen
   import ahb_lite_master_pkg::*;
#(
   parameter int MAX_LEN = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_load,
   input  logic                     i_advance,
   input  logic [BUS_WIDTH-1:0]     i_start_addr,
   input  logic [$clog2(MAX_LEN):0] i_len,
   input  logic [2:0]               i_size,
   output logic [BUS_WIDTH-1:0]     o_addr,
   output logic                     o_last_beat,
   output logic                     o_page_cross
);

   localparam int LEN_W = $clog2(MAX_LEN) + 1;

   logic [BUS_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]     remain_q, remain_d;
   logic [BUS_WIDTH-1:0] next_addr;
   logic [LEN_W-1:0]     eff_len;

   // Zero means one beat; anything past MAX_LEN is capped.
   always_comb begin
      eff_len = i_len;
      if (i_len == '0)
         eff_len = LEN_W'(1);
      else if (i_len > LEN_W'(MAX_LEN))
         eff_len = LEN_W'(MAX_LEN);
   end

   assign next_addr = addr_q + (32'd1 << i_size);

   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      if (i_load) begin
         addr_d   = i_start_addr;
         remain_d = eff_len;
      end else if (i_advance) begin
         addr_d   = next_addr;
         remain_d = remain_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         remain_q <= '0;
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
      end
   end

   assign o_addr       = addr_q;
   assign o_last_beat  = (remain_q == LEN_W'(1));
   assign o_page_cross = (next_addr[BUS_WIDTH-1:10] != addr_q[BUS_WIDTH-1:10]);

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_lite_master : AHB-Lite initiator, SINGLE/INCR bursts of 1..MAX_LEN beats
// Option macro AHB_MASTER_1KB_SPLIT_EN: restart with NONSEQ at 1KB pages. Rev 1.0
// ----------------------------------------------------------------------------
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter int         MAX_LEN   = 16,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESET,
   ahb_lite_master_if.master bus
);

`ifdef AHB_MASTER_1KB_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   localparam int LEN_W = $clog2(MAX_LEN) + 1;

   state_e               state_q, state_d;
   htrans_e              htrans_q, htrans_d;
   hburst_e              hburst_q, hburst_d;
   logic                 hwrite_q, hwrite_d;
   logic [2:0]           hsize_q, hsize_d;
   logic [BUS_WIDTH-1:0] hwdata_q, hwdata_d;
   logic                 dphase_q, dphase_d;
   logic                 dphase_wr_q, dphase_wr_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 done_q, done_d;
   logic                 done_err_q, done_err_d;
   logic                 cmd_ready_q, cmd_ready_d;

   logic                 wr_pop;
   logic                 ag_load;
   logic                 ag_adv;
   logic                 last_beat;
   logic                 page_cross;
   logic [BUS_WIDTH-1:0] haddr;
   logic                 err_first;
   logic                 err_last;

   ahb_lite_addr_gen #(
      .MAX_LEN (MAX_LEN)
   ) u_addr_gen (
      .clk          (HCLK),
      .rst          (HRESET),
      .i_load       (ag_load),
      .i_advance    (ag_adv),
      .i_start_addr (bus.cmd_addr),
      .i_len        (bus.cmd_len),
      .i_size       (hsize_q),
      .o_addr       (haddr),
      .o_last_beat  (last_beat),
      .o_page_cross (page_cross)
   );

   assign err_first = dphase_q && (bus.HRESP == RESP_ERROR) && !bus.HREADY;
   assign err_last  = dphase_q && (bus.HRESP == RESP_ERROR) && bus.HREADY;

   always_comb begin
      state_d     = state_q;
      htrans_d    = htrans_q;
      hburst_d    = hburst_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hwdata_d    = hwdata_q;
      dphase_d    = dphase_q;
      dphase_wr_d = dphase_wr_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      done_err_d  = 1'b0;
      wr_pop      = 1'b0;
      ag_load     = 1'b0;
      ag_adv      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               state_d  = ST_ADDR;
               htrans_d = HTRANS_NONSEQ;
               hwrite_d = bus.cmd_write;
               hsize_d  = clamp_size(bus.cmd_size);
               hburst_d = (bus.cmd_len <= LEN_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
               ag_load  = 1'b1;
            end
         end

         ST_ADDR: begin
            if (err_first) begin
               state_d  = ST_ERR;
               htrans_d = HTRANS_IDLE;
            end else if (err_last) begin
               state_d    = ST_IDLE;
               htrans_d   = HTRANS_IDLE;
               dphase_d   = 1'b0;
               done_d     = 1'b1;
               done_err_d = 1'b1;
            end else if (bus.HREADY) begin
               // Previous beat's data phase retires as this address is accepted.
               if (dphase_q && !dphase_wr_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.HRDATA;
               end
               dphase_d    = 1'b1;
               dphase_wr_d = hwrite_q;
               if (hwrite_q) begin
                  wr_pop   = 1'b1;
                  hwdata_d = bus.wr_data;
               end
               if (last_beat) begin
                  state_d  = ST_DATA;
                  htrans_d = HTRANS_IDLE;
               end else begin
                  ag_adv   = 1'b1;
                  htrans_d = (SPLIT_EN && page_cross) ? HTRANS_NONSEQ : HTRANS_SEQ;
               end
            end
         end

         ST_DATA: begin
            if (err_first) begin
               state_d = ST_ERR;
            end else if (bus.HREADY) begin
               state_d    = ST_IDLE;
               dphase_d   = 1'b0;
               done_d     = 1'b1;
               done_err_d = (bus.HRESP == RESP_ERROR);
               if (!dphase_wr_q && (bus.HRESP == RESP_OKAY)) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.HRDATA;
               end
            end
         end

         ST_ERR: begin
            if (bus.HREADY) begin
               state_d    = ST_IDLE;
               dphase_d   = 1'b0;
               done_d     = 1'b1;
               done_err_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Held low through the done cycle so a command there is not taken.
      cmd_ready_d = (state_d == ST_IDLE) && !done_d;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         htrans_q    <= HTRANS_IDLE;
         hburst_q    <= HBURST_SINGLE;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         hwdata_q    <= '0;
         dphase_q    <= 1'b0;
         dphase_wr_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         done_q      <= 1'b0;
         done_err_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         htrans_q    <= htrans_d;
         hburst_q    <= hburst_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hwdata_q    <= hwdata_d;
         dphase_q    <= dphase_d;
         dphase_wr_q <= dphase_wr_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         done_q      <= done_d;
         done_err_q  <= done_err_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // HTRANS drops to IDLE in the first ERROR cycle itself, not a cycle later.
   assign bus.HTRANS    = err_first ? HTRANS_IDLE : htrans_q;
   assign bus.HADDR     = haddr;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HSIZE     = hsize_q;
   assign bus.HBURST    = hburst_q;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HWDATA    = hwdata_q;
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.wr_pop    = wr_pop;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.done      = done_q;
   assign bus.done_err  = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ahb_lite_master : directed self-checking bench for ahb_lite_master
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ahb_lite_master;

`ifdef AHB_MASTER_1KB_SPLIT_EN
   localparam logic [31:0] EXP_CROSS = 32'h2;
`else
   localparam logic [31:0] EXP_CROSS = 32'h3;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pops  = 0;
   int   pops0;

   ahb_lite_master_if #(.MAX_LEN(16)) bus ();

   ahb_lite_master #(
      .MAX_LEN   (16),
      .HPROT_VAL (4'b0011)
   ) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.wr_pop === 1'b1)
         n_pops <= n_pops + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [4:0] len, input logic [31:0] wd);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_size  = sz;
      bus.cmd_len   = len;
      bus.wr_data   = wd;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_size  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 1'b0;
      bus.HRDATA    = '0;
      tick();
      tick();

      chk("rst_htrans",    32'(bus.HTRANS),    32'h0);
      chk("rst_haddr",     bus.HADDR,          32'h0);
      chk("rst_hwrite",    32'(bus.HWRITE),    32'h0);
      chk("rst_hsize",     32'(bus.HSIZE),     32'h0);
      chk("rst_hburst",    32'(bus.HBURST),    32'h0);
      chk("rst_hprot",     32'(bus.HPROT),     32'h3);
      chk("rst_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
      chk("rst_hwdata",    bus.HWDATA,         32'h0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
      chk("rst_wr_pop",    32'(bus.wr_pop),    32'h0);
      chk("rst_rd_valid",  32'(bus.rd_valid),  32'h0);
      chk("rst_rd_data",   bus.rd_data,        32'h0);
      chk("rst_done",      32'(bus.done),      32'h0);
      chk("rst_done_err",  32'(bus.done_err),  32'h0);
      rst = 1'b0;

      // Single zero-wait write
      issue(1'b1, 32'h10, 3'd2, 5'd1, 32'hDEADBEEF);
      chk("w1_htrans",    32'(bus.HTRANS),    32'h2);
      chk("w1_haddr",     bus.HADDR,          32'h10);
      chk("w1_hburst",    32'(bus.HBURST),    32'h0);
      chk("w1_hwrite",    32'(bus.HWRITE),    32'h1);
      chk("w1_hsize",     32'(bus.HSIZE),     32'h2);
      chk("w1_cmd_ready", 32'(bus.cmd_ready), 32'h0);
      chk("w1_wr_pop",    32'(bus.wr_pop),    32'h1);
      tick();
      chk("w1_htrans_idle", 32'(bus.HTRANS), 32'h0);
      chk("w1_hwdata",      bus.HWDATA,      32'hDEADBEEF);
      chk("w1_wr_pop_off",  32'(bus.wr_pop), 32'h0);
      chk("w1_done_early",  32'(bus.done),   32'h0);
      tick();
      chk("w1_done",      32'(bus.done),      32'h1);
      chk("w1_done_err",  32'(bus.done_err),  32'h0);
      chk("w1_ready_low", 32'(bus.cmd_ready), 32'h0);
      tick();
      chk("w1_done_off",  32'(bus.done),      32'h0);
      chk("w1_ready_up",  32'(bus.cmd_ready), 32'h1);

      // Single read, len 0 treated as 1, two data-phase wait states
      issue(1'b0, 32'h20, 3'd2, 5'd0, 32'h0);
      chk("r1_htrans", 32'(bus.HTRANS), 32'h2);
      chk("r1_haddr",  bus.HADDR,       32'h20);
      chk("r1_hburst", 32'(bus.HBURST), 32'h0);
      chk("r1_hwrite", 32'(bus.HWRITE), 32'h0);
      chk("r1_wr_pop", 32'(bus.wr_pop), 32'h0);
      tick();
      bus.HREADY = 1'b0;
      tick();
      chk("r1_wait_haddr",  bus.HADDR,         32'h20);
      chk("r1_wait_htrans", 32'(bus.HTRANS),   32'h0);
      chk("r1_wait_hwdata", bus.HWDATA,        32'hDEADBEEF);
      chk("r1_wait_rdv",    32'(bus.rd_valid), 32'h0);
      chk("r1_wait_done",   32'(bus.done),     32'h0);
      tick();
      bus.HREADY = 1'b1;
      bus.HRDATA = 32'hCAFEF00D;
      tick();
      bus.HRDATA = 32'h0;
      chk("r1_rd_valid", 32'(bus.rd_valid), 32'h1);
      chk("r1_rd_data",  bus.rd_data,       32'hCAFEF00D);
      chk("r1_done",     32'(bus.done),     32'h1);
      chk("r1_done_err", 32'(bus.done_err), 32'h0);
      tick();
      chk("r1_rdv_off",  32'(bus.rd_valid),  32'h0);
      chk("r1_ready",    32'(bus.cmd_ready), 32'h1);

      // 4-beat INCR halfword read with one wait on beat 1
      issue(1'b0, 32'h100, 3'd1, 5'd4, 32'h0);
      chk("r4_htrans0", 32'(bus.HTRANS), 32'h2);
      chk("r4_haddr0",  bus.HADDR,       32'h100);
      chk("r4_hburst",  32'(bus.HBURST), 32'h1);
      chk("r4_hsize",   32'(bus.HSIZE),  32'h1);
      tick();
      chk("r4_htrans1", 32'(bus.HTRANS), 32'h3);
      chk("r4_haddr1",  bus.HADDR,       32'h102);
      bus.HRDATA = 32'h1111;
      tick();
      chk("r4_rdv0",    32'(bus.rd_valid), 32'h1);
      chk("r4_rdd0",    bus.rd_data,       32'h1111);
      chk("r4_htrans2", 32'(bus.HTRANS),   32'h3);
      chk("r4_haddr2",  bus.HADDR,         32'h104);
      bus.HREADY = 1'b0;
      tick();
      chk("r4_hold_htrans", 32'(bus.HTRANS),   32'h3);
      chk("r4_hold_haddr",  bus.HADDR,         32'h104);
      chk("r4_hold_rdv",    32'(bus.rd_valid), 32'h0);
      bus.HREADY = 1'b1;
      bus.HRDATA = 32'h2222;
      tick();
      chk("r4_rdd1",    bus.rd_data,     32'h2222);
      chk("r4_htrans3", 32'(bus.HTRANS), 32'h3);
      chk("r4_haddr3",  bus.HADDR,       32'h106);
      bus.HRDATA = 32'h3333;
      tick();
      chk("r4_rdd2",      bus.rd_data,     32'h3333);
      chk("r4_htrans_id", 32'(bus.HTRANS), 32'h0);
      bus.HRDATA = 32'h4444;
      tick();
      chk("r4_rdv3",  32'(bus.rd_valid), 32'h1);
      chk("r4_rdd3",  bus.rd_data,       32'h4444);
      chk("r4_done",  32'(bus.done),     32'h1);
      chk("r4_derr",  32'(bus.done_err), 32'h0);
      bus.HRDATA = 32'h0;
      tick();

      // 4-beat word write at 0x3F8, ERROR on the second beat
      pops0 = n_pops;
      issue(1'b1, 32'h3F8, 3'd2, 5'd4, 32'hA0);
      chk("e_htrans0", 32'(bus.HTRANS), 32'h2);
      chk("e_haddr0",  bus.HADDR,       32'h3F8);
      chk("e_wr_pop0", 32'(bus.wr_pop), 32'h1);
      tick();
      bus.wr_data = 32'hA1;
      chk("e_htrans1", 32'(bus.HTRANS), 32'h3);
      chk("e_haddr1",  bus.HADDR,       32'h3FC);
      chk("e_hwdata0", bus.HWDATA,      32'hA0);
      tick();
      bus.wr_data = 32'hA2;
      chk("e_hwdata1",     bus.HWDATA,      32'hA1);
      chk("e_haddr2",      bus.HADDR,       32'h400);
      chk("e_htrans_page", 32'(bus.HTRANS), EXP_CROSS);
      bus.HRESP  = 1'b1;
      bus.HREADY = 1'b0;
      #1;
      chk("e_err1_htrans", 32'(bus.HTRANS), 32'h0);
      chk("e_err1_wr_pop", 32'(bus.wr_pop), 32'h0);
      tick();
      bus.HREADY = 1'b1;
      #1;
      chk("e_err2_htrans", 32'(bus.HTRANS), 32'h0);
      chk("e_err2_wr_pop", 32'(bus.wr_pop), 32'h0);
      chk("e_err2_done",   32'(bus.done),   32'h0);
      tick();
      bus.HRESP = 1'b0;
      chk("e_done",     32'(bus.done),     32'h1);
      chk("e_done_err", 32'(bus.done_err), 32'h1);
      tick();
      chk("e_ready",    32'(bus.cmd_ready),   32'h1);
      chk("e_done_off", 32'(bus.done),        32'h0);
      chk("e_pops",     32'(n_pops - pops0),  32'h2);

      // HRESET during beat 3 of an 8-beat read
      issue(1'b0, 32'h200, 3'd2, 5'd8, 32'h0);
      chk("x_haddr0", bus.HADDR, 32'h200);
      tick();
      chk("x_haddr1", bus.HADDR, 32'h204);
      tick();
      chk("x_haddr2", bus.HADDR, 32'h208);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("x_htrans", 32'(bus.HTRANS),    32'h0);
      chk("x_haddr",  bus.HADDR,          32'h0);
      chk("x_hburst", 32'(bus.HBURST),    32'h0);
      chk("x_hsize",  32'(bus.HSIZE),     32'h0);
      chk("x_hwdata", bus.HWDATA,         32'h0);
      chk("x_ready",  32'(bus.cmd_ready), 32'h1);
      chk("x_rdv",    32'(bus.rd_valid),  32'h0);
      chk("x_done",   32'(bus.done),      32'h0);
      tick();
      chk("x_done2",  32'(bus.done),      32'h0);

      // Post-reset write with illegal size clamped to word
      issue(1'b1, 32'h44, 3'b111, 5'd1, 32'h12345678);
      chk("p_hsize",  32'(bus.HSIZE),  32'h2);
      chk("p_haddr",  bus.HADDR,       32'h44);
      chk("p_htrans", 32'(bus.HTRANS), 32'h2);
      chk("p_wr_pop", 32'(bus.wr_pop), 32'h1);
      tick();
      chk("p_hwdata", bus.HWDATA, 32'h12345678);
      tick();
      chk("p_done",     32'(bus.done),     32'h1);
      chk("p_done_err", 32'(bus.done_err), 32'h0);
      tick();
      chk("p_ready", 32'(bus.cmd_ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
